mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_pkg.sv | 10 +
 rtl/mac_mult.sv | 15 +
 rtl/mac_unit.sv | 55 +++++
 tb/tb_mac_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the signed multiply-accumulate unit.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 19;
    localparam int PROD_W = 2 * DATA_W;

    typedef logic signed [ACC_W-1:0] acc_t;

endpackage : mac_pkg

// File: rtl/mac_mult.sv
// Combinational full-precision signed DATA_W x DATA_W multiplier.
module mac_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = mac_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    // Both operands are signed, so the product is exact in 2*DATA_W bits.
    assign p_o = a_i * b_i;

endmodule : mac_mult

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: acc <= (clear ? 0 : acc) + inA*inB, one result per cycle.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              macc_clear,
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    output logic [ACC_W-1:0]  macc_out
);

    localparam int P_W = 2 * DATA_W;

    logic signed [P_W-1:0]   prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a_i (inA),
        .b_i (inB),
        .p_o (prod_s)
    );

    // Sign-extend the product, add, and select between load and accumulate.
    always_comb begin
        prod_ext_s = {{(ACC_W-P_W){prod_s[P_W-1]}}, prod_s};
        sum_s      = acc_q + prod_ext_s;
        acc_d      = sum_s;
        if (macc_clear) begin
            acc_d = prod_ext_s;
        end else begin
            acc_d = sum_s;
        end
    end

    // Accumulator register; reset wins over clear and operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign macc_out = acc_q;

endmodule : mac_unit

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit using directed vectors with hand-computed sums.
module tb_mac_unit;

    localparam int DW = 8;
    localparam int AW = 19;

    typedef struct {
        int    exp;
        string name;
    } sb_item_t;

    logic                 clk;
    logic                 rst_n;
    logic                 macc_clear;
    logic signed [DW-1:0] inA;
    logic signed [DW-1:0] inB;
    logic signed [AW-1:0] macc_out;

    sb_item_t sb_q[$];
    int       n_checks;
    int       n_errors;

    mac_unit #(
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .macc_clear (macc_clear),
        .inA        (inA),
        .inB        (inB),
        .macc_out   (macc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge consumes the vector issued before it.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            n_checks++;
            if (int'(macc_out) != it.exp) begin
                n_errors++;
                $display("FAIL %s: got %0d expected %0d", it.name, int'(macc_out), it.exp);
            end
        end
    end

    task automatic step(input logic rst, input logic clr, input int a, input int b,
                        input int exp, input string name);
        sb_item_t it;
        @(negedge clk);
        rst_n      = rst;
        macc_clear = clr;
        inA        = DW'(a);
        inB        = DW'(b);
        it.exp     = exp;
        it.name    = name;
        sb_q.push_back(it);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        macc_clear = 1'b0;
        inA        = '0;
        inB        = '0;

        // Reset with live operands, then a cleared zero load.
        step(1'b0, 1'b0, 5, 5, 0, "reset0");
        step(1'b0, 1'b0, 5, 5, 0, "reset1");
        step(1'b1, 1'b1, 0, 0, 0, "clear_zero");

        // Basic accumulation.
        step(1'b1, 1'b0, 3, 2, 6, "sum0");
        step(1'b1, 1'b0, 4, 3, 18, "sum1");
        step(1'b1, 1'b0, -2, 5, 8, "sum2");
        step(1'b1, 1'b0, 1, -3, 5, "sum3");

        // Clear-load discards the old sum with no idle cycle.
        step(1'b1, 1'b1, 6, 2, 12, "clear_load");
        step(1'b1, 1'b0, 8, 8, 76, "after_clear");

        // Worst-case eight-term dot product.
        step(1'b1, 1'b1, -128, -128, 16384, "ext_clear");
        for (int i = 2; i <= 8; i++) begin
            step(1'b1, 1'b0, -128, -128, 16384 * i, $sformatf("ext_acc%0d", i));
        end
        step(1'b1, 1'b1, -128, 127, -16256, "ext_mixed");
        step(1'b1, 1'b0, 127, 127, -127, "ext_pos");

        // Wrap modulo 2^19.
        step(1'b1, 1'b1, -128, -128, 16384, "wrap1");
        for (int i = 2; i <= 15; i++) begin
            step(1'b1, 1'b0, -128, -128, 16384 * i, $sformatf("wrap%0d", i));
        end
        step(1'b1, 1'b0, -128, -128, -262144, "wrap16");
        step(1'b1, 1'b0, -128, -128, -245760, "wrap17");

        // Reset beats clear mid-sum; release starts from zero.
        step(1'b1, 1'b1, 4, 4, 16, "pri_pre");
        step(1'b0, 1'b1, 9, 9, 0, "pri_reset");
        step(1'b1, 1'b0, 2, 3, 6, "pri_release");

        // A reset pulse between edges must not disturb the sum.
        step(1'b1, 1'b0, 1, 1, 7, "glitch");
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, -1, 7, 0, "post_glitch");

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d pending expected 0", sb_q.size());
        end
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mac_unit
